// File: rtl/sum_sq_accum_if.sv
// Element-in / result-out stream bundle for the sum-of-squares engine.
// master drives elements and takes results; slave is the engine side.
interface sum_sq_accum_if #(
  parameter int unsigned WIDTH = 26
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sum_sq_accum.sv
// Sequential sum-of-squares of N_ELEM signed Q13.13 elements, unsigned Q13.13 result with
// round-half-up and sticky saturation; one radix-2 shift-add step per cycle.
module sum_sq_accum #(
  parameter int unsigned WIDTH  = 26,
  parameter int unsigned FRAC   = 13,
  parameter int unsigned N_ELEM = 4
) (
  input logic          clk,
  input logic          rst_n,
  sum_sq_accum_if.slave bus
);

  localparam int unsigned CntW = $clog2(N_ELEM + 1);
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned RndW = 2 * WIDTH - FRAC + 1;
  localparam logic [WIDTH:0] AccMax = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    count_q;
  logic [BitW-1:0]    bit_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     acc_q;
  logic               sat_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_sat_q;

  logic [WIDTH-1:0] abs_in;
  logic [WIDTH:0]   step_sum;
  logic [RndW-1:0]  r_full;
  logic             r_big;
  logic [WIDTH:0]   acc_sum;
  logic             clamp;
  logic [WIDTH:0]   acc_next;
  logic             last_elem;

  // Most negative input maps to 2^(WIDTH-1), which still fits as unsigned.
  assign abs_in = bus.in_data[WIDTH-1] ? (~bus.in_data + WIDTH'(1)) : bus.in_data;

  // Upper half of prod_q accumulates; lower half holds the multiplier, consumed LSB first.
  assign step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  // Adding the first discarded bit to the truncated value is round half up.
  assign r_full = {1'b0, prod_q[2*WIDTH-1:FRAC]} + RndW'(prod_q[FRAC-1]);
  assign r_big  = |r_full[RndW-1:WIDTH];

  always_comb begin
    acc_sum  = acc_q + {1'b0, r_full[WIDTH-1:0]};
    clamp    = r_big || (acc_sum > AccMax);
    acc_next = clamp ? AccMax : acc_sum;
  end

  assign last_elem = (count_q == CntW'(N_ELEM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      bit_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            mcand_q    <= abs_in;
            prod_q     <= {{WIDTH{1'b0}}, abs_in};
            bit_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StMul;
          end
        end
        StMul: begin
          prod_q <= {step_sum, prod_q[WIDTH-1:1]};
          bit_q  <= bit_q + BitW'(1);
          if (bit_q == BitW'(WIDTH - 1)) begin
            state_q <= StAcc;
          end
        end
        StAcc: begin
          acc_q   <= acc_next;
          sat_q   <= sat_q | clamp;
          count_q <= count_q + CntW'(1);
          if (last_elem) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_next[WIDTH-1:0];
            out_sat_q   <= sat_q | clamp;
            state_q     <= StDone;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Bench for sum_sq_accum: an N_ELEM=4 and an N_ELEM=1 instance sharing one stimulus stream,
// checked against an arithmetic sum-of-squares model.
module tb_sum_sq_accum;

  localparam int unsigned W = 26;
  localparam longint MaxVal = 64'd67108863;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;  // 0: N_ELEM=4 instance, 1: N_ELEM=1 instance
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  int n_vec = 0;
  int n_mis = 0;

  sum_sq_accum_if #(.WIDTH(W)) bus4 ();
  sum_sq_accum_if #(.WIDTH(W)) bus1 ();

  assign bus4.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus4.in_data   = in_data;
  assign bus1.in_data   = in_data;
  assign bus4.out_ready = out_ready & ~sel;
  assign bus1.out_ready = out_ready & sel;

  sum_sq_accum #(.WIDTH(W), .FRAC(13), .N_ELEM(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  sum_sq_accum #(.WIDTH(W), .FRAC(13), .N_ELEM(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  logic         o_in_ready, o_out_valid, o_out_sat;
  logic [W-1:0] o_out_data;
  assign o_in_ready  = sel ? bus1.in_ready  : bus4.in_ready;
  assign o_out_valid = sel ? bus1.out_valid : bus4.out_valid;
  assign o_out_data  = sel ? bus1.out_data  : bus4.out_data;
  assign o_out_sat   = sel ? bus1.out_sat   : bus4.out_sat;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the block is ready or has a result.
  task automatic send(input logic [W-1:0] x);
    int waited = 0;
    int busy = 0;
    while (!o_in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(o_in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!o_in_ready && !o_out_valid && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy), 32'(W + 1));
  endtask

  task automatic run_vector(input logic s, input int n, input logic [W-1:0] e0,
                            input logic [W-1:0] e1, input logic [W-1:0] e2,
                            input logic [W-1:0] e3, input int hold);
    logic [W-1:0] el[4];
    longint acc = 0;
    longint v;
    longint r;
    logic   sat = 1'b0;
    el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
    sel = s;
    for (int i = 0; i < n; i++) begin
      v = longint'($signed(el[i]));
      r = (v * v + 64'd4096) >>> 13;
      if (acc + r > MaxVal) begin
        acc = MaxVal;
        sat = 1'b1;
      end else begin
        acc = acc + r;
      end
    end
    out_ready = (hold == 0);
    for (int i = 0; i < n; i++) send(el[i]);
    check("out_valid", 32'(o_out_valid), 32'd1);
    check("out_data", 32'(o_out_data), 32'(acc));
    check("out_sat", 32'(o_out_sat), 32'(sat));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(o_out_valid), 32'd1);
      check("hold_data", 32'(o_out_data), 32'(acc));
      check("hold_sat", 32'(o_out_sat), 32'(sat));
      check("hold_in_ready", 32'(o_in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_drop", 32'(o_out_valid), 32'd0);
    check("idle_in_ready", 32'(o_in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] rnd_elem();
    logic [W-1:0] x;
    case ($urandom_range(0, 2))
      0:       x = W'($urandom) & 26'h0003FFF;
      1:       x = W'($urandom) & 26'h003FFFF;
      default: x = W'($urandom);
    endcase
    if ($urandom_range(0, 1) == 1) x = ~x + W'(1);
    return x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready4"}, 32'(bus4.in_ready), 32'd0);
    check({tag, "_valid4"}, 32'(bus4.out_valid), 32'd0);
    check({tag, "_data4"}, 32'(bus4.out_data), 32'd0);
    check({tag, "_sat4"}, 32'(bus4.out_sat), 32'd0);
    check({tag, "_in_ready1"}, 32'(bus1.in_ready), 32'd0);
    check({tag, "_valid1"}, 32'(bus1.out_valid), 32'd0);
    check({tag, "_data1"}, 32'(bus1.out_data), 32'd0);
    check({tag, "_sat1"}, 32'(bus1.out_sat), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("first_idle_in_ready4", 32'(bus4.in_ready), 32'd1);
    check("first_idle_in_ready1", 32'(bus1.in_ready), 32'd1);

    // Single 1.0, then the 2.5 vector.
    run_vector(1'b1, 1, 26'h0002000, '0, '0, '0, 0);
    run_vector(1'b0, 4, 26'h0002000, 26'h3FFE000, 26'h0001000, 26'h0001000, 0);

    // Rounding boundaries.
    run_vector(1'b1, 1, 26'd1, '0, '0, '0, 0);
    run_vector(1'b1, 1, 26'd64, '0, '0, '0, 0);
    run_vector(1'b1, 1, 26'd91, '0, '0, '0, 0);

    // Saturation from the most negative input, then the sticky flag clears.
    run_vector(1'b1, 1, 26'h2000000, '0, '0, '0, 0);
    run_vector(1'b1, 1, 26'h0002000, '0, '0, '0, 0);

    // Back-pressure with junk elements offered while the result waits.
    run_vector(1'b0, 4, 26'h0003000, 26'h3FFF000, 26'h0000800, 26'h0100000, 10);

    // Abort mid-multiply on the third element of an N_ELEM=4 vector.
    sel = 1'b0;
    out_ready = 1'b1;
    send(26'h0004000);
    send(26'h0004000);
    in_valid = 1'b1;
    in_data  = 26'h0004000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vector(1'b0, 4, 26'h0002000, 26'h0002000, 26'h0002000, 26'h0002000, 0);
    run_vector(1'b1, 1, 26'h0002000, '0, '0, '0, 0);

    for (int k = 0; k < 16; k++) begin
      run_vector(1'b0, 4, rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem(),
                 int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 10; k++) begin
      run_vector(1'b1, 1, rnd_elem(), '0, '0, '0, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
